// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC sequencing controller (adc_seq_ctrl).
package adc_seq_pkg;

    localparam int unsigned ADC_W = 8;

    typedef enum logic [1:0] {
        ST_CAL  = 2'd0,
        ST_MEAS = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Signed measurement result relative to the calibrated zero code.
    typedef struct packed {
        logic             neg;
        logic [ADC_W-1:0] mag;
    } res_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adc_clk_div.sv
// ADC sample clock generator: 50% duty ad_clk plus a one-cycle strobe that
// marks the sys_clk cycle ending on the ad_clk rising edge.
module adc_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic ad_clk_o,
    output logic strobe_o
);

    localparam int unsigned     DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             ad_clk_q, ad_clk_d;
    logic             strobe_q, strobe_d;

    // Outputs are decoded from the next count so they line up with div_cnt_q.
    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        ad_clk_d  = (div_cnt_d < DIV_HALF);
        strobe_d  = (div_cnt_d == DIV_LAST);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_cnt_q <= '0;
            ad_clk_q  <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            ad_clk_q  <= ad_clk_d;
            strobe_q  <= strobe_d;
        end
    end

    assign ad_clk_o = ad_clk_q;
    assign strobe_o = strobe_q;

endmodule

// File: rtl/adc_seq_ctrl.sv
// ADC sequencing controller: zero-offset calibration, windowed averaging and
// valid/ready result delivery. ADC_OVR_CNT_EN adds the discarded-strobe counter.
module adc_seq_ctrl
    import adc_seq_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned CAL_LEN_LOG2 = 10,
    parameter int unsigned AVG_LEN_LOG2 = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [ADC_W-1:0] ad_data,
    input  logic             recal,
    output logic             ad_clk,
    output logic             cal_done,
    output logic [ADC_W-1:0] zero_code,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_neg,
    output logic [ADC_W-1:0] res_mag
`ifdef ADC_OVR_CNT_EN
    ,
    output logic [7:0]       ovr_cnt
`endif
);

    localparam int unsigned CNT_W = max_u(CAL_LEN_LOG2, AVG_LEN_LOG2);
    localparam int unsigned ACC_W = ADC_W + CNT_W;
    localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'((32'd1 << CAL_LEN_LOG2) - 32'd1);
    localparam logic [CNT_W-1:0] AVG_LAST = CNT_W'((32'd1 << AVG_LEN_LOG2) - 32'd1);

    logic strobe;

    adc_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk_i    (sys_clk),
        .rst_n_i  (sys_rst_n),
        .ad_clk_o (ad_clk),
        .strobe_o (strobe)
    );

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cal_done_q, cal_done_d;
    logic [ADC_W-1:0] zero_q, zero_d;
    logic             valid_q, valid_d;
    res_t             res_q, res_d;
`ifdef ADC_OVR_CNT_EN
    logic [7:0]       ovr_q, ovr_d;
`endif

    logic [ACC_W-1:0] sum_c;
    logic [ADC_W-1:0] cal_avg_c, meas_avg_c, mag_c;
    logic [ADC_W:0]   diff_c;
    logic             last_c;

    // Datapath: running sum including the current strobe sample, and the
    // signed distance of the window average from the zero code.
    assign sum_c      = acc_q + ACC_W'(ad_data);
    assign cal_avg_c  = ADC_W'(sum_c >> CAL_LEN_LOG2);
    assign meas_avg_c = ADC_W'(sum_c >> AVG_LEN_LOG2);
    assign diff_c     = {1'b0, meas_avg_c} - {1'b0, zero_q};
    assign mag_c      = diff_c[ADC_W] ? ADC_W'(-diff_c) : diff_c[ADC_W-1:0];
    assign last_c     = (cnt_q == ((state_q == ST_CAL) ? CAL_LAST : AVG_LAST));

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        cal_done_d = cal_done_q;
        zero_d     = zero_q;
        valid_d    = valid_q;
        res_d      = res_q;
`ifdef ADC_OVR_CNT_EN
        ovr_d      = ovr_q;
`endif
        if (recal) begin
            // zero_q is kept until the new calibration pass finishes.
            state_d    = ST_CAL;
            acc_d      = '0;
            cnt_d      = '0;
            cal_done_d = 1'b0;
            valid_d    = 1'b0;
`ifdef ADC_OVR_CNT_EN
            ovr_d      = '0;
`endif
        end else begin
            case (state_q)
                ST_CAL: begin
                    if (strobe) begin
                        if (last_c) begin
                            zero_d     = cal_avg_c;
                            cal_done_d = 1'b1;
                            acc_d      = '0;
                            cnt_d      = '0;
                            state_d    = ST_MEAS;
                        end else begin
                            acc_d = sum_c;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_MEAS: begin
                    if (strobe) begin
                        if (last_c) begin
                            res_d.neg = diff_c[ADC_W];
                            res_d.mag = mag_c;
                            valid_d   = 1'b1;
                            acc_d     = '0;
                            cnt_d     = '0;
                            state_d   = ST_HOLD;
                        end else begin
                            acc_d = sum_c;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    // Strobes here are dropped, including one on the accept cycle.
`ifdef ADC_OVR_CNT_EN
                    if (strobe && (ovr_q != 8'hFF)) begin
                        ovr_d = ovr_q + 8'd1;
                    end
`endif
                    if (valid_q && res_ready) begin
                        valid_d = 1'b0;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_MEAS;
                    end
                end
                default: begin
                    state_d = ST_CAL;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_CAL;
            acc_q      <= '0;
            cnt_q      <= '0;
            cal_done_q <= 1'b0;
            zero_q     <= '0;
            valid_q    <= 1'b0;
            res_q      <= '0;
`ifdef ADC_OVR_CNT_EN
            ovr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            cal_done_q <= cal_done_d;
            zero_q     <= zero_d;
            valid_q    <= valid_d;
            res_q      <= res_d;
`ifdef ADC_OVR_CNT_EN
            ovr_q      <= ovr_d;
`endif
        end
    end

    assign cal_done  = cal_done_q;
    assign zero_code = zero_q;
    assign res_valid = valid_q;
    assign res_neg   = res_q.neg;
    assign res_mag   = res_q.mag;
`ifdef ADC_OVR_CNT_EN
    assign ovr_cnt   = ovr_q;
`endif

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Bench for adc_seq_ctrl: directed scenarios plus randomized traffic checked
// against a sample-queue reference model.
module tb_adc_seq_ctrl;

    localparam int CLK_DIV = 4;
    localparam int CAL_N   = 16;
    localparam int AVG_N   = 4;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic [7:0] ad_data   = 8'h00;
    logic       recal     = 1'b0;
    logic       res_ready = 1'b0;
    logic       ad_clk, cal_done, res_valid, res_neg;
    logic [7:0] zero_code, res_mag;
`ifdef ADC_OVR_CNT_EN
    logic [7:0] ovr_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    adc_seq_ctrl #(
        .CLK_DIV      (4),
        .CAL_LEN_LOG2 (4),
        .AVG_LEN_LOG2 (2)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .ad_data   (ad_data),
        .recal     (recal),
        .ad_clk    (ad_clk),
        .cal_done  (cal_done),
        .zero_code (zero_code),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_neg   (res_neg),
        .res_mag   (res_mag)
`ifdef ADC_OVR_CNT_EN
        ,
        .ovr_cnt   (ovr_cnt)
`endif
    );

    // Reference model: cycles counted from reset release, samples collected
    // in a queue and averaged with integer division when the window is full.
    typedef enum int {M_CAL, M_MEAS, M_HOLD} mph_e;
    mph_e       ph         = M_CAL;
    int         cyc        = 0;
    int         smp[$];
    int         m_total    = 0;
    int         m_avg      = 0;
    int         m_ovr      = 0;
    logic [7:0] m_zero     = 8'h00;
    logic [7:0] m_mag      = 8'h00;
    logic       m_neg      = 1'b0;
    logic       m_cal_done = 1'b0;
    logic       m_valid    = 1'b0;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cyc = 0; ph = M_CAL; smp.delete();
            m_zero = 8'h00; m_mag = 8'h00; m_neg = 1'b0;
            m_cal_done = 1'b0; m_valid = 1'b0; m_ovr = 0;
        end else begin
            cyc++;
            if (recal) begin
                ph = M_CAL; smp.delete();
                m_cal_done = 1'b0; m_valid = 1'b0; m_ovr = 0;
            end else if (ph == M_HOLD) begin
                if ((cyc % CLK_DIV == 0) && m_ovr < 255) m_ovr++;
                if (m_valid && res_ready) begin
                    m_valid = 1'b0;
                    ph = M_MEAS;
                end
            end else if (cyc % CLK_DIV == 0) begin
                smp.push_back(int'(ad_data));
                m_total = 0;
                foreach (smp[i]) m_total += smp[i];
                if (ph == M_CAL && smp.size() == CAL_N) begin
                    m_zero = 8'(m_total / CAL_N);
                    m_cal_done = 1'b1;
                    smp.delete();
                    ph = M_MEAS;
                end else if (ph == M_MEAS && smp.size() == AVG_N) begin
                    m_avg = m_total / AVG_N;
                    m_neg = (m_avg < int'(m_zero));
                    m_mag = 8'(m_neg ? int'(m_zero) - m_avg : m_avg - int'(m_zero));
                    m_valid = 1'b1;
                    smp.delete();
                    ph = M_HOLD;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0; recal = 1'b0; res_ready = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    // Waits for cal_done (which=0) or res_valid (which=1); at = cycle or -1.
    task automatic wait_sig(input int which, input int max_cyc, output int at);
        at = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge sys_clk);
            if ((which == 0 && cal_done === 1'b1) || (which == 1 && res_valid === 1'b1)) begin
                at = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset();
        #1 sys_rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            checks++;
            if ({ad_clk, cal_done, zero_code, res_valid, res_neg, res_mag} !== 20'h0) begin
                errors++;
                $display("FAIL reset_values got ad_clk=%b cal_done=%b zero=%h valid=%b neg=%b mag=%h required all 0",
                         ad_clk, cal_done, zero_code, res_valid, res_neg, res_mag);
            end
`ifdef ADC_OVR_CNT_EN
            checks++;
            if (ovr_cnt !== 8'h00) begin
                errors++;
                $display("FAIL reset_ovr got %h required 00", ovr_cnt);
            end
`endif
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_clock();
        int highs = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge sys_clk);
            highs += int'(ad_clk);
            checks++;
            if (ad_clk !== ((cyc % CLK_DIV) < CLK_DIV / 2)) begin
                errors++;
                $display("FAIL ad_clk_phase cyc=%0d got %b required %b", cyc, ad_clk, (cyc % CLK_DIV) < CLK_DIV / 2);
            end
        end
        checks++;
        if (highs != 8) begin
            errors++;
            $display("FAIL ad_clk_duty got %0d high cycles of 16 required 8", highs);
        end
    endtask

    task automatic test_cal_const();
        int at;
        do_reset();
        ad_data = 8'h80;
        wait_sig(0, 200, at);
        checks++;
        if (at != CAL_N * CLK_DIV) begin
            errors++;
            $display("FAIL cal_done_latency got cycle %0d required %0d", at, CAL_N * CLK_DIV);
        end
        checks++;
        if (zero_code !== 8'h80) begin
            errors++;
            $display("FAIL cal_const_zero got %h required 80", zero_code);
        end
    endtask

    task automatic test_cal_alt();
        bit done = 0;
        do_reset();
        for (int i = 0; i < 200 && !done; i++) begin
            ad_data = ((cyc / CLK_DIV) % 2 == 1) ? 8'h82 : 8'h7F;
            @(negedge sys_clk);
            done = (cal_done === 1'b1);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL cal_alt_timeout got cal_done=%b required 1", cal_done);
        end
        checks++;
        if (zero_code !== 8'h80 || zero_code !== m_zero) begin
            errors++;
            $display("FAIL cal_alt_zero got %h required 80 (model %h)", zero_code, m_zero);
        end
    endtask

    task automatic test_meas();
        int at;
        ad_data = 8'h90;
        wait_sig(1, 100, at);
        checks++;
        if (at < 0 || res_neg !== 1'b0 || res_mag !== 8'h10) begin
            errors++;
            $display("FAIL meas_above got valid=%b neg=%b mag=%h required 1 0 10", res_valid, res_neg, res_mag);
        end
        ad_data = 8'h70; res_ready = 1'b1;
        @(negedge sys_clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_drop got valid=%b required 0", res_valid);
        end
        wait_sig(1, 100, at);
        checks++;
        if (at < 0 || res_neg !== 1'b1 || res_mag !== 8'h10) begin
            errors++;
            $display("FAIL meas_below got valid=%b neg=%b mag=%h required 1 1 10", res_valid, res_neg, res_mag);
        end
        ad_data = 8'h80; res_ready = 1'b1;
        @(negedge sys_clk);
        res_ready = 1'b0;
        wait_sig(1, 100, at);
        checks++;
        if (at < 0 || res_neg !== 1'b0 || res_mag !== 8'h00) begin
            errors++;
            $display("FAIL meas_equal got valid=%b neg=%b mag=%h required 1 0 00", res_valid, res_neg, res_mag);
        end
    endtask

    task automatic test_backpressure();
        int at;
        int bad = 0;
        ad_data = 8'h20; res_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (res_valid !== 1'b1 || res_mag !== 8'h00 || res_neg !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable got %0d unstable cycles required 0", bad);
        end
`ifdef ADC_OVR_CNT_EN
        checks++;
        if (ovr_cnt !== 8'(m_ovr) || m_ovr != 10) begin
            errors++;
            $display("FAIL ovr_count got %0d required %0d (model) and 10", ovr_cnt, m_ovr);
        end
`endif
        ad_data = 8'h90; res_ready = 1'b1;
        @(negedge sys_clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept got valid=%b required 0", res_valid);
        end
        wait_sig(1, 100, at);
        checks++;
        if (at < 0 || res_neg !== 1'b0 || res_mag !== 8'h10) begin
            errors++;
            $display("FAIL bp_fresh got valid=%b neg=%b mag=%h required 1 0 10", res_valid, res_neg, res_mag);
        end
    endtask

    task automatic test_recal();
        int at;
        int bad = 0;
        bit done = 0;
        res_ready = 1'b1;
        @(negedge sys_clk);
        res_ready = 1'b0;
        repeat (2) @(negedge sys_clk);
        ad_data = 8'h60; recal = 1'b1;
        @(negedge sys_clk);
        recal = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || cal_done !== 1'b0 || zero_code !== 8'h80) begin
            errors++;
            $display("FAIL recal_meas got valid=%b cal_done=%b zero=%h required 0 0 80", res_valid, cal_done, zero_code);
        end
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge sys_clk);
            if (cal_done !== m_cal_done) bad++;
            done = (cal_done === 1'b1);
            if (!done && zero_code !== 8'h80) bad++;
        end
        checks++;
        if (!done || bad != 0 || zero_code !== 8'h60) begin
            errors++;
            $display("FAIL recal_cal got done=%b bad=%0d zero=%h required 1 0 60", done, bad, zero_code);
        end
        wait_sig(1, 100, at);
        ad_data = 8'h50; recal = 1'b1; res_ready = 1'b1;
        @(negedge sys_clk);
        recal = 1'b0; res_ready = 1'b0;
        checks++;
        if (at < 0 || res_valid !== 1'b0 || cal_done !== 1'b0 || zero_code !== 8'h60) begin
            errors++;
            $display("FAIL recal_hs got valid=%b cal_done=%b zero=%h required 0 0 60", res_valid, cal_done, zero_code);
        end
        wait_sig(0, 200, at);
        checks++;
        if (at < 0 || zero_code !== 8'h50) begin
            errors++;
            $display("FAIL recal_hs_cal got zero=%h required 50", zero_code);
        end
    endtask

    task automatic test_async_reset();
        int at;
        ad_data = 8'h90;
        wait_sig(1, 100, at);
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if (at < 0 || {ad_clk, cal_done, zero_code, res_valid, res_neg, res_mag} !== 20'h0) begin
            errors++;
            $display("FAIL async_reset got ad_clk=%b cal_done=%b zero=%h valid=%b neg=%b mag=%h required all 0",
                     ad_clk, cal_done, zero_code, res_valid, res_neg, res_mag);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1; ad_data = 8'h80;
        wait_sig(0, 200, at);
        checks++;
        if (at != CAL_N * CLK_DIV || zero_code !== 8'h80) begin
            errors++;
            $display("FAIL post_reset_cal got cycle %0d zero=%h required %0d 80", at, zero_code, CAL_N * CLK_DIV);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge sys_clk);
            checks++;
            if ({ad_clk, cal_done, res_valid} !== {((cyc % CLK_DIV) < CLK_DIV / 2), m_cal_done, m_valid}) begin
                errors++;
                $display("FAIL rand_ctrl cyc=%0d got ad_clk/cal_done/valid=%b%b%b required %b%b%b", cyc,
                         ad_clk, cal_done, res_valid, ((cyc % CLK_DIV) < CLK_DIV / 2), m_cal_done, m_valid);
            end
            checks++;
            if ({zero_code, res_neg, res_mag} !== {m_zero, m_neg, m_mag}) begin
                errors++;
                $display("FAIL rand_data cyc=%0d got zero=%h neg=%b mag=%h required %h %b %h", cyc,
                         zero_code, res_neg, res_mag, m_zero, m_neg, m_mag);
            end
`ifdef ADC_OVR_CNT_EN
            checks++;
            if (ovr_cnt !== 8'(m_ovr)) begin
                errors++;
                $display("FAIL rand_ovr cyc=%0d got %0d required %0d", cyc, ovr_cnt, m_ovr);
            end
`endif
            ad_data   = 8'($urandom);
            res_ready = ($urandom_range(0, 3) == 0);
            recal     = ($urandom_range(0, 299) == 0);
        end
        recal = 1'b0; res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clock();
        test_cal_const();
        test_cal_alt();
        test_meas();
        test_backpressure();
        test_recal();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
